// File: rtl/sev_seg_mux.sv
// sev_seg_mux: time-multiplexed N-digit seven-segment driver for common-anode displays.
// Outputs lag the slot counter/digit index by one cycle and are fully registered.
// Flow control: upd is a one-cycle capture strobe into a pending buffer; the new data
// goes live only at the next frame boundary.
//
// Ports:
//   clk, rst     : clock; asynchronous active-high reset
//   din, dp_in   : digit codes (nibble i -> digit i, digit 0 rightmost) and dp enables
//   upd          : capture strobe for din/dp_in
//   lz_en        : leading-zero suppression enable (level)
//   a_to_g, an, dp : active-low segment, anode and decimal-point drives (registered)
//   upd_pending  : captured data is waiting for the next frame boundary
//   frame_pulse  : one-cycle pulse in the cycle after a frame boundary
module sev_seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int HEX_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    upd,
  input  logic                    lz_en,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    upd_pending,
  output logic                    frame_pulse
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW:0]   BLANK_END = (CW+1)'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  // Scan state
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  // Double-buffered display data
  logic [4*NUM_DIGITS-1:0] r_act;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pflag;

  // Registered pin drives
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_wrap;
  logic                    w_boundary;
  logic                    w_blank;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [3:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_sup;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_boundary = w_wrap && (r_idx == IDX_LAST);
  assign w_blank    = ({1'b0, r_cnt} < BLANK_END);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nib[i] = r_act[4*i +: 4];
    end
  end

  assign w_code = w_nib[r_idx];

  // A digit is suppressed while every digit from the most significant one down to
  // it is zero; digit 0 is excluded so a value of zero still shows a single '0'.
  always_comb begin
    w_sup = '0;
    w_run = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run    = w_run & (w_nib[i] == 4'h0);
      w_sup[i] = w_run;
    end
  end

  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      // Legacy set: A = dash, B = blank, C = underscore, D-F = blank
      4'hA: seg = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
      4'hB: seg = (HEX_MODE != 0) ? 7'h03 : SEG_OFF;
      4'hC: seg = (HEX_MODE != 0) ? 7'h46 : 7'h77;
      4'hD: seg = (HEX_MODE != 0) ? 7'h21 : SEG_OFF;
      4'hE: seg = (HEX_MODE != 0) ? 7'h06 : SEG_OFF;
      4'hF: seg = (HEX_MODE != 0) ? 7'h0E : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Slot counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Display buffers: an upd landing exactly on the boundary bypasses the pending
  // buffer so the new frame shows it without waiting a further frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act     <= {NUM_DIGITS{4'hB}};
      r_act_dp  <= '0;
      r_pend    <= '0;
      r_pend_dp <= '0;
      r_pflag   <= 1'b0;
    end else if (w_boundary) begin
      if (upd) begin
        r_act    <= din;
        r_act_dp <= dp_in;
      end else if (r_pflag) begin
        r_act    <= r_pend;
        r_act_dp <= r_pend_dp;
      end
      r_pflag <= 1'b0;
    end else if (upd) begin
      r_pend    <= din;
      r_pend_dp <= dp_in;
      r_pflag   <= 1'b1;
    end
  end

  // Output stage: blanking at the start of each slot prevents ghosting while the
  // anode switches over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= SEG_OFF;
      r_an    <= '1;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (w_blank) begin
        r_seg <= SEG_OFF;
        r_an  <= '1;
        r_dp  <= 1'b1;
      end else begin
        r_seg <= w_sup[r_idx] ? SEG_OFF : f_decode(w_code);
        r_an  <= w_an_sel;
        r_dp  <= ~r_act_dp[r_idx];
      end
    end
  end

  assign a_to_g      = r_seg;
  assign an          = r_an;
  assign dp          = r_dp;
  assign upd_pending = r_pflag;
  assign frame_pulse = r_frame;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Testbench for sev_seg_mux: two instances (legacy and hex glyph sets) share stimulus
// and are compared every cycle against a frame/slot arithmetic model of the display.
// Directed scenarios first, then a randomized phase.
module tb_sev_seg_mux;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [4*N-1:0] din = '0;
  logic [N-1:0]  dp_in = '0;
  logic          upd = 1'b0;
  logic          lz_en = 1'b0;

  logic [6:0]    seg0, seg1;
  logic [N-1:0]  an0, an1;
  logic          dp0, dp1, pend0, pend1, frm0, frm1;

  sev_seg_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(0)) u_leg (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .upd(upd), .lz_en(lz_en),
    .a_to_g(seg0), .an(an0), .dp(dp0), .upd_pending(pend0), .frame_pulse(frm0)
  );

  sev_seg_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .upd(upd), .lz_en(lz_en),
    .a_to_g(seg1), .an(an1), .dp(dp1), .upd_pending(pend1), .frame_pulse(frm1)
  );

  int errors = 0;
  int checks = 0;

  // Glyph tables indexed by code
  logic [6:0] leg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h7F, 7'h77, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: cycles since reset plus the two display buffers
  int         m_c;
  logic [3:0] m_act  [N];
  logic [3:0] m_pend [N];
  logic [N-1:0] m_act_dp, m_pend_dp;
  bit         m_pflag;

  task automatic model_reset();
    m_c = 0;
    for (int k = 0; k < N; k++) begin
      m_act[k]  = 4'hB;
      m_pend[k] = 4'h0;
    end
    m_act_dp  = '0;
    m_pend_dp = '0;
    m_pflag   = 1'b0;
  endtask

  function automatic logic [6:0] exp_seg(input int d, input bit hex);
    bit all_zero;
    all_zero = 1'b1;
    for (int k = N - 1; k >= d; k--) begin
      if (m_act[k] != 4'h0) all_zero = 1'b0;
    end
    if (lz_en && d > 0 && all_zero) return 7'h7F;
    return hex ? hex_tab[m_act[d]] : leg_tab[m_act[d]];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"},  {1'b0, seg0}, 8'h7F);
    chk({tag, "_an"},   {4'h0, an0},  8'h0F);
    chk({tag, "_dp"},   {7'h0, dp0},  8'h01);
    chk({tag, "_pend"}, {7'h0, pend0}, 8'h00);
    chk({tag, "_frm"},  {7'h0, frm0}, 8'h00);
    chk({tag, "_hseg"}, {1'b0, seg1}, 8'h7F);
    chk({tag, "_han"},  {4'h0, an1},  8'h0F);
    chk({tag, "_hpend"}, {7'h0, pend1}, 8'h00);
  endtask

  // One clock: predict outputs from pre-edge model state and current inputs,
  // advance the model, then sample the DUT 1 ns after the edge.
  task automatic step();
    int pos, dig;
    bit bnd;
    logic [6:0] es0, es1;
    logic [N-1:0] ean, onehot;
    logic edp;
    pos = m_c % DIV;
    dig = (m_c / DIV) % N;
    bnd = (m_c % FRAME) == FRAME - 1;
    if (pos < BLK) begin
      es0 = 7'h7F; es1 = 7'h7F; ean = '1; edp = 1'b1;
    end else begin
      es0 = exp_seg(dig, 1'b0);
      es1 = exp_seg(dig, 1'b1);
      onehot = '0;
      onehot[dig] = 1'b1;
      ean = ~onehot;
      edp = ~m_act_dp[dig];
    end
    if (bnd) begin
      if (upd) begin
        for (int k = 0; k < N; k++) m_act[k] = din[4*k +: 4];
        m_act_dp = dp_in;
      end else if (m_pflag) begin
        for (int k = 0; k < N; k++) m_act[k] = m_pend[k];
        m_act_dp = m_pend_dp;
      end
      m_pflag = 1'b0;
    end else if (upd) begin
      for (int k = 0; k < N; k++) m_pend[k] = din[4*k +: 4];
      m_pend_dp = dp_in;
      m_pflag   = 1'b1;
    end
    m_c++;
    @(posedge clk);
    #1;
    chk("seg",   {1'b0, seg0},  {1'b0, es0});
    chk("an",    {4'h0, an0},   {4'h0, ean});
    chk("dp",    {7'h0, dp0},   {7'h0, edp});
    chk("pend",  {7'h0, pend0}, {7'h0, m_pflag});
    chk("frame", {7'h0, frm0},  {7'h0, bnd});
    chk("hseg",  {1'b0, seg1},  {1'b0, es1});
    chk("han",   {4'h0, an1},   {4'h0, ean});
    chk("hdp",   {7'h0, dp1},   {7'h0, edp});
    chk("hpend", {7'h0, pend1}, {7'h0, m_pflag});
    chk("hframe", {7'h0, frm1}, {7'h0, bnd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int frame_pos);
    for (int i = 0; i < FRAME && (m_c % FRAME) != frame_pos; i++) step();
  endtask

  task automatic strobe(input logic [4*N-1:0] d, input logic [N-1:0] p);
    din = d; dp_in = p; upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state, clock running with rst held
    @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Blank scan after reset
    run(40);

    // Mid-frame update 1234 with dp on digit 2
    run_to(10);
    strobe(16'h1234, 4'b0100);
    run(2 * FRAME);

    // Two captures in one frame: the later one wins
    run_to(3);
    strobe(16'h1111, 4'b0000);
    run(5);
    strobe(16'h2222, 4'b0001);
    run(2 * FRAME);

    // Capture exactly on the boundary cycle bypasses the pending buffer
    run_to(FRAME - 1);
    strobe(16'h0AB0, 4'b1000);
    run(FRAME);

    // Leading-zero suppression on and off
    run_to(12);
    strobe(16'h0070, 4'b0000);
    lz_en = 1'b1;
    run(2 * FRAME);
    lz_en = 1'b0;
    run(FRAME);

    // Hex glyph set
    run_to(6);
    strobe(16'hABCD, 4'b0000);
    run(2 * FRAME);

    // Asynchronous reset mid-slot discards pending data
    run_to(5);
    strobe(16'h5678, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run(2 * FRAME);

    // Randomized phase: zero-biased digits to exercise suppression
    for (int i = 0; i < 800; i++) begin
      logic [4*N-1:0] d;
      for (int k = 0; k < N; k++) begin
        d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      din   = d;
      dp_in = N'($urandom_range(0, (1 << N) - 1));
      upd   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      step();
    end
    upd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
